// File: rtl/cpu_pkg.sv
// Shared definitions for the operand SRAM controller: opcode values,
// instruction field positions, FSM state encoding and field extractors.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 16;
    localparam int RS1_HI = 15;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_WB       = 3'd5
    } state_t;

    function automatic logic [3:0] instr_opcode(input logic [31:0] i);
        return i[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [7:0] instr_rd(input logic [31:0] i);
        return i[RD_HI:RD_LO];
    endfunction

    function automatic logic [7:0] instr_rs1(input logic [31:0] i);
        return i[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [7:0] instr_rs2(input logic [31:0] i);
        return i[RS2_HI:RS2_LO];
    endfunction

endpackage

// File: rtl/sram_timeout_ctr.sv
// Result-wait watchdog: cleared on load, counts while enabled, saturates,
// and flags expiry when the count sits at TIMEOUT-1.
module sram_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (en && count_reg != SAT) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expire = (count_reg == LAST);

endmodule

// File: rtl/sram_operand_ctrl.sv
// Operand SRAM initiator: dual-reads two sources, hands them to the execute
// unit, waits (with timeout) for the result and writes it back to rd.
module sram_operand_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR    = 8,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic                mem_cs,
    output logic                mem_we,
    output logic [2*ADDR-1:0]   mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata1,
    input  logic [WIDTH-1:0]    mem_rdata2,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [3:0]          op_code,
    output logic [WIDTH-1:0]    op_a,
    output logic [WIDTH-1:0]    op_b,
    input  logic                res_valid,
    input  logic [WIDTH-1:0]    res_data,
    output logic                done,
    output logic                err,
    output logic                busy
);

    state_t          state_reg;
    logic [ADDR-1:0] rd_reg;
    logic            ctr_load;
    logic            ctr_en;
    logic            ctr_expire;
    logic            unused_reserved;

    assign unused_reserved = ^instr[27:24];

    assign ctr_load = (state_reg == ST_ISSUE) && op_valid && op_ready;
    assign ctr_en   = (state_reg == ST_WAIT_RES) && !res_valid;

    sram_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (ctr_load),
        .en     (ctr_en),
        .expire (ctr_expire)
    );

    // All outputs are registered: each branch sets the outputs of the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rd_reg      <= '0;
            instr_ready <= 1'b1;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            op_valid    <= 1'b0;
            op_code     <= '0;
            op_a        <= '0;
            op_b        <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid) begin
                        rd_reg      <= ADDR'(instr_rd(instr));
                        op_code     <= instr_opcode(instr);
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (instr_opcode(instr) == OP_NOP) begin
                            // NOP retires through WB with the memory strobes left low.
                            state_reg <= ST_WB;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_RD_REQ;
                            mem_cs    <= 1'b1;
                            mem_addr  <= {ADDR'(instr_rs1(instr)), ADDR'(instr_rs2(instr))};
                        end
                    end
                end

                ST_RD_REQ: begin
                    state_reg <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    op_a      <= mem_rdata1;
                    op_b      <= mem_rdata2;
                    op_valid  <= 1'b1;
                    state_reg <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        state_reg <= ST_WAIT_RES;
                    end
                end

                ST_WAIT_RES: begin
                    if (res_valid) begin
                        state_reg <= ST_WB;
                        mem_cs    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {{ADDR{1'b0}}, rd_reg};
                        mem_wdata <= res_data;
                        done      <= 1'b1;
                    end else if (ctr_expire) begin
                        err         <= 1'b1;
                        state_reg   <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                ST_WB: begin
                    state_reg   <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    op_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_operand_ctrl.sv
// Directed bench: a behavioural SRAM plus a table of instructions with
// hand-computed operands, timing and write-back, and a reset-mid-op sequence.
module tb_sram_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        mem_cs;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata1;
    logic [31:0] mem_rdata2;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic [31:0] res_data;
    logic        done;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sram_operand_ctrl #(
        .ADDR    (8),
        .WIDTH   (32),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata1  (mem_rdata1),
        .mem_rdata2  (mem_rdata2),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .done        (done),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: registered dual read, single write on rd field.
    logic [31:0] mem [256];
    int total_writes = 0;

    always @(posedge clk) begin
        if (mem_cs && !mem_we) begin
            mem_rdata1 <= mem[mem_addr[15:8]];
            mem_rdata2 <= mem[mem_addr[7:0]];
        end
        if (mem_cs && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            total_writes       <= total_writes + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          ready_delay;
        int          res_delay;     // -1: never answer
        logic [31:0] res_value;
        int          exp_reads;
        logic [15:0] exp_raddr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          exp_done;      // cycle after accept, -1 none
        int          exp_err;
        int          exp_writes;
        logic [15:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        int          done_cyc;
        int          err_cyc;
        int          reads;
        int          writes;
        logic [15:0] raddr;
        logic [15:0] waddr;
        logic [31:0] wdata;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  opc;
        logic        stable;
        logic        busy_ok;
        logic        acc_ready;
        logic        ready_after;
        logic        err_after;
    } obs_t;

    function automatic vec_t mk(input string name, input logic [31:0] ins, input int rdy, input int rsd,
                                input logic [31:0] rv, input int nr, input logic [15:0] ra,
                                input logic [31:0] ea, input logic [31:0] eb, input int ed, input int ee,
                                input int nw, input logic [15:0] wa, input logic [31:0] wd);
        vec_t v;
        v.name = name; v.ins = ins; v.ready_delay = rdy; v.res_delay = rsd; v.res_value = rv;
        v.exp_reads = nr; v.exp_raddr = ra; v.exp_a = ea; v.exp_b = eb; v.exp_done = ed;
        v.exp_err = ee; v.exp_writes = nw; v.exp_waddr = wa; v.exp_wdata = wd;
        return v;
    endfunction

    task automatic run_op(input vec_t v, output obs_t o);
        int  iss = 0;
        int  hs  = -1;
        bit  fin = 0;
        o = '{done_cyc: -1, err_cyc: -1, reads: 0, writes: 0, raddr: '0, waddr: '0, wdata: '0,
              a: '0, b: '0, opc: '0, stable: 1'b1, busy_ok: 1'b1, acc_ready: 1'b0,
              ready_after: 1'b0, err_after: 1'b0};
        @(negedge clk);
        instr       = v.ins;
        instr_valid = 1'b1;
        o.acc_ready = instr_ready;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            res_valid = (hs >= 0 && v.res_delay >= 0 && cyc == hs + 1 + v.res_delay);
            res_data  = v.res_value;
            if (op_valid) begin
                if (iss == 0) begin
                    o.a = op_a; o.b = op_b; o.opc = op_code;
                end else if (op_a !== o.a || op_b !== o.b || op_code !== o.opc) begin
                    o.stable = 1'b0;
                end
                iss++;
                op_ready = (iss > v.ready_delay);
                if (op_ready) hs = cyc;
            end else begin
                op_ready = 1'b0;
            end
            if (mem_cs && !mem_we) begin o.reads++; o.raddr = mem_addr; end
            if (mem_cs && mem_we) begin o.writes++; o.waddr = mem_addr; o.wdata = mem_wdata; end
            if (err) begin
                o.err_cyc = cyc; fin = 1;
            end else begin
                if (!busy) o.busy_ok = 1'b0;
                if (done) begin o.done_cyc = cyc; fin = 1; end
            end
        end
        @(negedge clk);
        res_valid     = 1'b0;
        op_ready      = 1'b0;
        o.ready_after = instr_ready;
        o.err_after   = err;
    endtask

    task automatic check_vec(input vec_t v, input obs_t o);
        chk({v.name, "_accept_ready"}, 64'(o.acc_ready), 64'(1));
        chk({v.name, "_done_cycle"}, 64'(o.done_cyc), 64'(v.exp_done));
        chk({v.name, "_err_cycle"}, 64'(o.err_cyc), 64'(v.exp_err));
        chk({v.name, "_reads"}, 64'(o.reads), 64'(v.exp_reads));
        chk({v.name, "_writes"}, 64'(o.writes), 64'(v.exp_writes));
        chk({v.name, "_busy"}, 64'(o.busy_ok), 64'(1));
        chk({v.name, "_ready_after"}, 64'(o.ready_after), 64'(1));
        chk({v.name, "_err_after"}, 64'(o.err_after), 64'(0));
        if (v.exp_reads > 0) begin
            chk({v.name, "_raddr"}, 64'(o.raddr), 64'(v.exp_raddr));
            chk({v.name, "_op_a"}, 64'(o.a), 64'(v.exp_a));
            chk({v.name, "_op_b"}, 64'(o.b), 64'(v.exp_b));
            chk({v.name, "_op_code"}, 64'(o.opc), 64'(v.ins[31:28]));
            chk({v.name, "_stable"}, 64'(o.stable), 64'(1));
        end
        if (v.exp_writes > 0) begin
            chk({v.name, "_waddr"}, 64'(o.waddr), 64'(v.exp_waddr));
            chk({v.name, "_wdata"}, 64'(o.wdata), 64'(v.exp_wdata));
        end
        $display("op %-10s instr=%08h done@%0d err@%0d reads=%0d writes=%0d a=%08h b=%08h",
                 v.name, v.ins, o.done_cyc, o.err_cyc, o.reads, o.writes, o.a, o.b);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr_ready"}, 64'(instr_ready), 64'(1));
        chk({tag, "_mem_cs"}, 64'(mem_cs), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_op_valid"}, 64'(op_valid), 64'(0));
        chk({tag, "_op_code"}, 64'(op_code), 64'(0));
        chk({tag, "_op_a"}, 64'(op_a), 64'(0));
        chk({tag, "_op_b"}, 64'(op_b), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    vec_t vecs[8];
    obs_t obs;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; op_ready = 1'b0;
        res_valid = 1'b0; res_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h03] = 32'h11;       mem[8'h04] = 32'h22;
        mem[8'h10] = 32'h5;        mem[8'h20] = 32'h7;
        mem[8'hFF] = 32'hDEADBEEF; mem[8'h00] = 32'h12345678;

        //              name        instr         rdy rsd  res           nr raddr    a             b             done err nw waddr    wdata
        vecs[0] = mk("basic",    32'h10050304, 0,  0, 32'h33,        1, 16'h0304, 32'h11,       32'h22,       5,  -1, 1, 16'h0005, 32'h33);
        vecs[1] = mk("nop",      32'h00070102, 0,  0, 32'h0,         0, 16'h0,    32'h0,        32'h0,        1,  -1, 0, 16'h0,    32'h0);
        vecs[2] = mk("backpr",   32'h20060304, 4,  0, 32'hABCD,      1, 16'h0304, 32'h11,       32'h22,       9,  -1, 1, 16'h0006, 32'hABCD);
        vecs[3] = mk("inplace",  32'h30101020, 0,  0, 32'h6,         1, 16'h1020, 32'h5,        32'h7,        5,  -1, 1, 16'h0010, 32'h6);
        vecs[4] = mk("readback", 32'h40111010, 0,  0, 32'h99,        1, 16'h1010, 32'h6,        32'h6,        5,  -1, 1, 16'h0011, 32'h99);
        vecs[5] = mk("timeout",  32'h50120304, 0, -1, 32'h0,         1, 16'h0304, 32'h11,       32'h22,       -1, 12, 0, 16'h0,    32'h0);
        vecs[6] = mk("expiry",   32'h60130506, 0,  7, 32'h77,        1, 16'h0506, 32'h33,       32'hABCD,     12, -1, 1, 16'h0013, 32'h77);
        vecs[7] = mk("edges",    32'h7FFFFF00, 0,  0, 32'h1,         1, 16'hFF00, 32'hDEADBEEF, 32'h12345678, 5,  -1, 1, 16'h00FF, 32'h1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        $display("reset  outputs checked instr_ready=%0b busy=%0b", instr_ready, busy);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], obs);
            check_vec(vecs[i], obs);
        end
        chk("mem_after_inplace", 64'(mem[8'h10]), 64'(32'h6));
        chk("mem_after_edges", 64'(mem[8'hFF]), 64'(32'h1));

        // Reset while waiting for a result, then a stray late result.
        begin
            int wr_before;
            int waited = 0;
            wr_before = total_writes;
            @(negedge clk);
            instr = 32'h1_0_20_03_04; instr_valid = 1'b1; op_ready = 1'b1;
            @(posedge clk);
            #1 instr_valid = 1'b0;
            while (!op_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("midrst_reached_issue", 64'(op_valid), 64'(1));
            @(negedge clk);
            op_ready = 1'b0;
            chk("midrst_in_wait_busy", 64'(busy), 64'(1));
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs("midrst");
            rst = 1'b0;
            res_valid = 1'b1; res_data = 32'hBAD;
            repeat (2) @(negedge clk);
            res_valid = 1'b0;
            chk("midrst_stray_busy", 64'(busy), 64'(0));
            chk("midrst_stray_done", 64'(done), 64'(0));
            chk("midrst_no_write", 64'(total_writes), 64'(wr_before));
            chk("midrst_rd_kept", 64'(mem[8'h20]), 64'(32'h7));
            $display("midrst writes_before=%0d writes_after=%0d mem20=%08h", wr_before, total_writes, mem[8'h20]);
        end

        vecs[0].name = "post_rst";
        run_op(vecs[0], obs);
        check_vec(vecs[0], obs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sram_operand_ctrl.md
Name: sram_operand_ctrl

Overview:
Initiator for the single-port-write / dual-read-data operand SRAM. It accepts one instruction at a time and reads two source operands from the SRAM in one access. It hands the operands to the execute unit over a valid/ready handshake, waits for the result, and writes the result back to the destination address. It sits between instruction issue and the SRAM/ALU pair. It is the sole driver of SRAM CS/WE/address/write-data.

Parameters:
ADDR, 8, SRAM address width per operand field.
WIDTH, 32, data word width.
TIMEOUT, 255, max cycles in WAIT_RES before abort (≥1).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
instr_valid  in  1  instruction offered.
instr_ready  out  1  controller can accept (IDLE only).
instr  in  32  [31:28] opcode, [27:24] reserved, [23:16] rd, [15:8] rs1, [7:0] rs2.
mem_cs  out  1  SRAM chip select.
mem_we  out  1  1 = write, 0 = dual read.
mem_addr  out  2*ADDR  read: {rs1,rs2}; write: {0,rd}.
mem_wdata  out  WIDTH  write-back data.
mem_rdata1  in  WIDTH  word at mem_addr[15:8]; registered, valid one cycle after read strobe.
mem_rdata2  in  WIDTH  word at mem_addr[7:0]; same timing.
op_valid  out  1  operands presented to execute unit.
op_ready  in  1  execute unit accepts.
op_code  out  4  latched opcode.
op_a  out  WIDTH  operand 1.
op_b  out  WIDTH  operand 2.
res_valid  in  1  result strobe from execute unit.
res_data  in  WIDTH  result.
done  out  1  one-cycle pulse: instruction retired.
err  out  1  one-cycle pulse: timeout abort.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at posedge): state→IDLE, timeout counter cleared; all outputs 0 except instr_ready=1. Reset mid-operation drops the instruction; no write is issued.
- States: IDLE, RD_REQ, RD_WAIT, ISSUE, WAIT_RES, WB.
- IDLE: instr_ready=1. On instr_valid, latch instr.
  - opcode==0 (NOP): next cycle done=1 for one cycle, no memory access, then back to IDLE.
  - otherwise → RD_REQ.
- RD_REQ (1 cycle): mem_cs=1, mem_we=0, mem_addr={rs1,rs2} → RD_WAIT.
- RD_WAIT (1 cycle): capture mem_rdata1→op_a and mem_rdata2→op_b at the cycle end → ISSUE.
- ISSUE: op_valid=1. op_a/op_b/op_code stay stable until op_valid&&op_ready. On handshake → WAIT_RES with the counter loaded at 0.
- WAIT_RES: res_valid is sampled only in this state; res_valid in any other state is ignored.
  - On res_valid: latch res_data → WB.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without res_valid: err=1 for one cycle → IDLE, no write.
  - res_valid in the same cycle as expiry: the result wins and the block proceeds to WB.
- WB (1 cycle): mem_cs=1, mem_we=1, mem_addr={ADDR'b0,rd}, mem_wdata=result, done=1 → IDLE.
- mem_cs, mem_we and mem_addr are 0 outside RD_REQ/WB. mem_wdata is 0 outside WB.
- Minimum latency, accept to done, with op_ready=1 and res_valid in the first WAIT_RES cycle: 5 cycles. Next accept is possible the cycle after WB.
- rd==rs1 or rd==rs2 is legal: the read completes before the write. rs1==rs2 is legal.
- Address fields pass straight through with no wrap arithmetic. The counter is width clog2(TIMEOUT+1) and saturates rather than wraps.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_NOP=4'h0), instruction field positions (OPC_HI/LO, RD/RS1/RS2 slices), state encoding constants.
- One natural sub-module: sram_timeout_ctr, a load/enable/expire counter parameterised by TIMEOUT. The FSM and datapath stay in sram_operand_ctrl.

Test Plan:
- Basic op: mem[0x03]=0x11, mem[0x04]=0x22, instr=0x1_0_05_03_04, op_ready=1, ALU returns 0x33 one cycle after handshake → one read with mem_addr=0x0304; op_a=0x11, op_b=0x22; write mem[0x05]=0x33; done exactly 5 cycles after accept; busy high throughout.
- NOP: instr=0x0_0_07_01_02 → done the next cycle; mem_cs never asserted; instr_ready back to 1 the cycle after.
- Backpressure: op_ready held low 4 cycles → op_valid held and op_a/op_b stable all 4 cycles; handshake on cycle 5; done delayed by exactly 4 cycles.
- Timeout: TIMEOUT=8, res_valid never asserted → err pulses once after 8 WAIT_RES cycles; no mem_we; controller returns to IDLE. res_valid asserted on the expiry cycle instead → write-back occurs and err stays 0.
- In-place write: rd=rs1=0x10, mem[0x10]=5, ALU returns 6 → op_a=5; mem[0x10]=6 after WB; a following instruction reads 6.
- Reset mid-op: rst asserted during WAIT_RES → all outputs at reset values the next cycle; no write; a stray late res_valid is ignored; a new instruction then completes normally.
